// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared constants and helpers for the GPR write-port arbiter
// Purpose: register-file geometry and the "effective write" rule shared by
//          the arbiter and its pending-write queue. No ports.
package gpr_pkg;

    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);
    localparam int DW    = 32;
    localparam logic [AW-1:0] REG_ZERO = '0;

    // r0 is hardwired to zero, so a write aimed at it is no write at all.
    function automatic logic is_wr(input logic we, input logic [AW-1:0] a3);
        return we && (a3 != REG_ZERO);
    endfunction

endpackage

// File: rtl/gpr_wfifo.sv
// rtl/gpr_wfifo.sv - in-order pending-write queue with per-entry live bits
// Purpose: buffers requester-1 register writes. Entries can be killed in
//          place (squash) by a younger pipeline write to the same register;
//          killed entries still occupy a slot until they reach the head.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   push, push_addr, push_data  enqueue a live entry (caller guarantees !full)
//   pop                         drop the head entry (caller guarantees !empty)
//   squash, squash_addr         kill every queued entry with this address
//   q1_a/q2_a -> q1_hit/q2_hit  some live entry targets the queried address
//   head_live/addr/data         head entry view
//   empty, full, cnt            occupancy, dead entries included
module gpr_wfifo
    import gpr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [AW-1:0]              push_addr,
    input  logic [DW-1:0]              push_data,
    input  logic                       pop,
    input  logic                       squash,
    input  logic [AW-1:0]              squash_addr,
    input  logic [AW-1:0]              q1_a,
    input  logic [AW-1:0]              q2_a,
    output logic                       q1_hit,
    output logic                       q2_hit,
    output logic                       head_live,
    output logic [AW-1:0]              head_addr,
    output logic [DW-1:0]              head_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [DEPTH-1:0] live;
    logic [AW-1:0]    addr_mem [DEPTH];
    logic [DW-1:0]    data_mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    assign empty     = (cnt == '0);
    assign full      = (cnt == CW'(DEPTH));
    assign head_live = !empty && live[rd_ptr];
    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Live bits are cleared on pop as well, so a free slot is never live and
    // the hit search needs no occupancy mask.
    always_comb begin
        q1_hit = 1'b0;
        q2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (live[i] && (addr_mem[i] == q1_a)) q1_hit = 1'b1;
            if (live[i] && (addr_mem[i] == q2_a)) q2_hit = 1'b1;
        end
    end

    // Squash is applied before push so an entry enqueued in the same cycle
    // as a matching pipeline write stays live (it is the younger write).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && (addr_mem[i] == squash_addr)) live[i] <= 1'b0;
            end
            if (pop) begin
                live[rd_ptr] <= 1'b0;
                rd_ptr       <= rd_ptr + PW'(1);
            end
            if (push) begin
                live[wr_ptr] <= 1'b1;
                wr_ptr       <= wr_ptr + PW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/gpr_wport_arb.sv
// rtl/gpr_wport_arb.sv - GPR write-port arbiter and pending-write scoreboard
// Purpose: shares the single register-file write port between the pipeline
//          W stage (fixed priority) and a queued valid/ready return path,
//          reports pending writes for hazard checks and requests a W-stage
//          bubble when the queue head has been starved for MAX_WAIT cycles.
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   w0_we, w0_a3, w0_wd           pipeline write
//   w1_valid, w1_ready, w1_a3, w1_wd  return-path write handshake
//   q1_a/q1_busy, q2_a/q2_busy    decode source pending-write query
//   stall                         bubble request to the pipeline
//   gpr_we, gpr_a3, gpr_wd        register-file write port
//   fifo_cnt                      queue occupancy
module gpr_wport_arb
    import gpr_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int MAX_WAIT = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w0_we,
    input  logic [AW-1:0]           w0_a3,
    input  logic [DW-1:0]           w0_wd,
    input  logic                    w1_valid,
    output logic                    w1_ready,
    input  logic [AW-1:0]           w1_a3,
    input  logic [DW-1:0]           w1_wd,
    input  logic [AW-1:0]           q1_a,
    input  logic [AW-1:0]           q2_a,
    output logic                    q1_busy,
    output logic                    q2_busy,
    output logic                    stall,
    output logic                    gpr_we,
    output logic [AW-1:0]           gpr_a3,
    output logic [DW-1:0]           gpr_wd,
    output logic [$clog2(DEPTH):0]  fifo_cnt
);

    localparam int WW = $clog2(MAX_WAIT + 1);

    logic          w0;
    logic          push;
    logic          pop;
    logic          q1_hit;
    logic          q2_hit;
    logic          head_live;
    logic [AW-1:0] head_addr;
    logic [DW-1:0] head_data;
    logic          empty;
    logic          full;
    logic [WW-1:0] wait_cnt;
    logic [WW-1:0] wait_nxt;

    assign w0       = is_wr(w0_we, w0_a3);
    assign w1_ready = !full;
    // A write to r0 completes the handshake but is dropped here.
    assign push     = w1_valid && w1_ready && (w1_a3 != REG_ZERO);
    // Dead heads drain without using the port; a live head waits for w0.
    assign pop      = !empty && !(head_live && w0);

    assign q1_busy  = (q1_a != REG_ZERO) && q1_hit;
    assign q2_busy  = (q2_a != REG_ZERO) && q2_hit;

    gpr_wfifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push),
        .push_addr   (w1_a3),
        .push_data   (w1_wd),
        .pop         (pop),
        .squash      (w0),
        .squash_addr (w0_a3),
        .q1_a        (q1_a),
        .q2_a        (q2_a),
        .q1_hit      (q1_hit),
        .q2_hit      (q2_hit),
        .head_live   (head_live),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .empty       (empty),
        .full        (full),
        .cnt         (fifo_cnt)
    );

    always_comb begin
        gpr_we = 1'b0;
        gpr_a3 = REG_ZERO;
        gpr_wd = '0;
        if (w0) begin
            gpr_we = 1'b1;
            gpr_a3 = w0_a3;
            gpr_wd = w0_wd;
        end else if (head_live) begin
            gpr_we = 1'b1;
            gpr_a3 = head_addr;
            gpr_wd = head_data;
        end
    end

    // Blocked exactly when the head is live and w0 owns the port; every other
    // case (pop, empty, dead head) restarts the count.
    always_comb begin
        wait_nxt = '0;
        if (head_live && w0) begin
            wait_nxt = (wait_cnt == WW'(MAX_WAIT)) ? wait_cnt : wait_cnt + WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            stall    <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            stall    <= (wait_nxt == WW'(MAX_WAIT));
        end
    end

endmodule

// File: tb/tb_gpr_wport_arb.sv
// tb/tb_gpr_wport_arb.sv - scoreboard bench for gpr_wport_arb
module tb_gpr_wport_arb;

    localparam int DEPTH    = 4;
    localparam int MAX_WAIT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        w0_we = 1'b0;
    logic [4:0]  w0_a3 = '0;
    logic [31:0] w0_wd = '0;
    logic        w1_valid = 1'b0;
    logic        w1_ready;
    logic [4:0]  w1_a3 = '0;
    logic [31:0] w1_wd = '0;
    logic [4:0]  q1_a = '0;
    logic [4:0]  q2_a = '0;
    logic        q1_busy;
    logic        q2_busy;
    logic        stall;
    logic        gpr_we;
    logic [4:0]  gpr_a3;
    logic [31:0] gpr_wd;
    logic [2:0]  fifo_cnt;

    gpr_wport_arb #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .w0_we(w0_we), .w0_a3(w0_a3), .w0_wd(w0_wd),
        .w1_valid(w1_valid), .w1_ready(w1_ready), .w1_a3(w1_a3), .w1_wd(w1_wd),
        .q1_a(q1_a), .q2_a(q2_a), .q1_busy(q1_busy), .q2_busy(q2_busy),
        .stall(stall), .gpr_we(gpr_we), .gpr_a3(gpr_a3), .gpr_wd(gpr_wd),
        .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {logic [4:0] a; logic [31:0] d; bit live;} ent_t;
    typedef struct {logic [4:0] a; logic [31:0] d;} wr_t;
    typedef struct {bit rdy; int cnt; bit b1; bit b2; bit stl;} st_t;

    ent_t mq[$];
    wr_t  exp_q[$];
    st_t  st_q[$];
    int   mwait = 0;
    bit   mstall = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit pending(input logic [4:0] q);
        if (q == 5'd0) return 0;
        foreach (mq[i]) if (mq[i].live && mq[i].a == q) return 1;
        return 0;
    endfunction

    // One clock cycle of stimulus; the model predicts this cycle's outputs
    // from the pending-write list, then advances it past the coming edge.
    task automatic cycle(input bit rst, input bit we, input logic [4:0] a0, input logic [31:0] d0,
                         input bit v, input logic [4:0] a1, input logic [31:0] d1,
                         input logic [4:0] qa, input logic [4:0] qb);
        st_t s;
        bit w0, ne, hl, rdy;
        @(posedge clk);
        #1;
        rst_n = !rst; w0_we = we; w0_a3 = a0; w0_wd = d0;
        w1_valid = v; w1_a3 = a1; w1_wd = d1; q1_a = qa; q2_a = qb;
        if (rst) begin
            mq.delete(); mwait = 0; mstall = 0;
        end
        s.rdy = (mq.size() < DEPTH); s.cnt = mq.size();
        s.b1 = pending(qa); s.b2 = pending(qb); s.stl = mstall;
        st_q.push_back(s);
        w0  = !rst && we && (a0 != 5'd0);
        ne  = mq.size() > 0;
        hl  = ne && mq[0].live;
        rdy = s.rdy;
        if (w0) exp_q.push_back('{a0, d0});
        else if (hl) exp_q.push_back('{mq[0].a, mq[0].d});
        if (!rst) begin
            if (ne && !(hl && w0)) mq.delete(0);
            if (w0) foreach (mq[i]) if (mq[i].a == a0) mq[i].live = 0;
            if (v && rdy && a1 != 5'd0) mq.push_back('{a1, d1, 1'b1});
            mwait  = (hl && w0) ? ((mwait < MAX_WAIT) ? mwait + 1 : MAX_WAIT) : 0;
            mstall = (mwait == MAX_WAIT);
        end
    endtask

    task automatic idle(input int n, input logic [4:0] qa);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, qa, qa);
    endtask

    // Monitor: compares status every cycle and pops a write expectation
    // whenever the port presents a write.
    always @(negedge clk) begin
        st_t s;
        wr_t w;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("w1_ready", 32'(w1_ready), 32'(s.rdy));
            chk("fifo_cnt", 32'(fifo_cnt), 32'(s.cnt));
            chk("q1_busy", 32'(q1_busy), 32'(s.b1));
            chk("q2_busy", 32'(q2_busy), 32'(s.b2));
            chk("stall", 32'(stall), 32'(s.stl));
        end
        if (gpr_we) begin
            if (exp_q.size() == 0) begin
                chk("spurious_write_a3", 32'(gpr_a3), 32'h0);
                chk("spurious_write_we", 32'(gpr_we), 32'h0);
            end else begin
                w = exp_q.pop_front();
                chk("gpr_a3", 32'(gpr_a3), 32'(w.a));
                chk("gpr_wd", gpr_wd, w.d);
            end
        end else begin
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("missing_write_we", 32'(gpr_we), 32'h1);
            end
            chk("idle_a3", 32'(gpr_a3), 32'h0);
            chk("idle_wd", gpr_wd, 32'h0);
        end
    end

    initial begin
        bit we;
        // reset
        for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2, 0);
        // basic W1 write to r5
        cycle(0, 0, 0, 0, 1, 5, 32'h1234, 5, 5);
        idle(3, 5);
        // priority and stall: W0 holds the port while r7 waits
        cycle(0, 1, 1, 32'h100, 1, 7, 32'h77, 7, 1);
        for (int i = 0; i < 5; i++) cycle(0, 1, 1, 32'h101 + i, 0, 0, 0, 7, 1);
        idle(3, 7);
        // squash: r9=AAAA queued, then W0 writes r9=BBBB
        cycle(0, 1, 2, 32'h22, 1, 9, 32'hAAAA, 9, 2);
        cycle(0, 1, 9, 32'hBBBB, 0, 0, 0, 9, 9);
        idle(3, 9);
        // same-cycle enqueue survives a matching W0 write
        cycle(0, 1, 2, 32'h23, 1, 11, 32'h11, 11, 2);
        cycle(0, 1, 11, 32'h12, 1, 11, 32'h13, 11, 11);
        idle(3, 11);
        // full queue, then r0 push and W0 to r0
        for (int i = 0; i < 6; i++)
            cycle(0, 1, 1, 32'h200 + i, 1, 5'(10 + (i % 4)), 32'h300 + i, 10, 13);
        cycle(0, 0, 0, 0, 0, 0, 0, 10, 13);
        cycle(0, 1, 1, 32'h210, 1, 0, 32'hDEAD, 11, 0);
        idle(8, 12);
        cycle(0, 1, 0, 32'hBEEF, 0, 0, 0, 0, 0);
        idle(2, 0);
        // wrap and order: 10 back-to-back writes to r3
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 3, 32'(i + 1), 3, 3);
        idle(3, 3);
        // reset mid-stream with 3 entries queued
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 32'h400 + i, 1, 5'(20 + i), 32'h500 + i, 20, 22);
        cycle(1, 0, 0, 0, 0, 0, 0, 20, 21);
        idle(4, 20);
        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            we = mstall ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) != 0);
            cycle(0, we, 5'($urandom_range(0, 7)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        idle(12, 0);
        @(negedge clk);
        #1;
        chk("final_exp_q_empty", 32'(exp_q.size()), 32'h0);
        chk("final_model_empty", 32'(mq.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
